// File: rtl/chan_fifo_arbiter.sv
// +--------------------------------------------------------------------------+
// | chan_fifo_arbiter                                                        |
// | Round-robin merge of NUM_SRC byte FIFOs into one framed byte stream.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module chan_fifo_arbiter #(
  parameter int NUM_SRC   = 4,
  parameter int MAX_BURST = 16
) (
  input  logic                 clk_in,
  input  logic                 reset_in,
  input  logic                 enable_in,
  input  logic [NUM_SRC-1:0]   srcMask_in,
  input  logic [NUM_SRC*8-1:0] srcData_in,
  input  logic [NUM_SRC-1:0]   srcEmpty_in,
  input  logic [NUM_SRC*8-1:0] srcCount_in,
  output logic [NUM_SRC-1:0]   srcRead_out,
  output logic [7:0]           dstData_out,
  output logic                 dstWrite_out,
  input  logic                 dstFull_in,
  output logic                 busy_out,
  output logic [2:0]           curSrc_out,
  output logic [5:0]           remain_out
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_HEADER = 2'd1,
    S_BURST  = 2'd2
  } state_t;

  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);

  state_t     state_q;
  logic [2:0] ptr_q;
  logic [2:0] cur_q;
  logic [5:0] remain_q;
  logic [4:0] lenm1_q;

  logic [NUM_SRC-1:0] elig_w;
  logic               grant_vld_d;
  logic [2:0]         grant_idx_d;
  logic [7:0]         grant_cnt_w;
  logic [5:0]         len_d;
  int                 dist_w;
  int                 best_w;
  logic [7:0]         cur_data_w;
  logic               cur_empty_w;
  logic               xfer_w;

  assign elig_w = srcMask_in & ~srcEmpty_in;

  // Winner is the eligible source at the smallest forward distance from ptr+1.
  always_comb begin
    grant_vld_d = 1'b0;
    grant_idx_d = 3'd0;
    best_w      = NUM_SRC;
    dist_w      = 0;
    for (int i = 0; i < NUM_SRC; i++) begin
      dist_w = (i + 2 * NUM_SRC - int'(ptr_q) - 1) % NUM_SRC;
      if (elig_w[i] && (dist_w < best_w)) begin
        best_w      = dist_w;
        grant_idx_d = 3'(i);
        grant_vld_d = 1'b1;
      end
    end
  end

  always_comb begin
    grant_cnt_w = 8'd0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_idx_d == 3'(i)) grant_cnt_w = srcCount_in[8*i +: 8];
    end
    if (grant_cnt_w == 8'd0)
      len_d = 6'd1;
    else if (grant_cnt_w > MAX_BURST_C)
      len_d = 6'(MAX_BURST);
    else
      len_d = grant_cnt_w[5:0];
  end

  always_comb begin
    cur_data_w  = 8'd0;
    cur_empty_w = 1'b1;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (cur_q == 3'(i)) begin
        cur_data_w  = srcData_in[8*i +: 8];
        cur_empty_w = srcEmpty_in[i];
      end
    end
  end

  // Strobes are masked by reset so an abandoned burst issues no further pops or writes.
  assign xfer_w = (state_q == S_BURST) && !dstFull_in && !cur_empty_w && !reset_in;

  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_q  <= S_IDLE;
      ptr_q    <= 3'(NUM_SRC - 1);
      cur_q    <= 3'd0;
      remain_q <= 6'd0;
      lenm1_q  <= 5'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (enable_in && grant_vld_d) begin
            cur_q    <= grant_idx_d;
            remain_q <= len_d;
            lenm1_q  <= 5'(len_d - 6'd1);
            state_q  <= S_HEADER;
          end
        end
        S_HEADER: begin
          if (!dstFull_in) state_q <= S_BURST;
        end
        S_BURST: begin
          if (xfer_w) begin
            remain_q <= remain_q - 6'd1;
            if (remain_q == 6'd1) begin
              ptr_q   <= cur_q;
              state_q <= S_IDLE;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    dstData_out  = 8'd0;
    dstWrite_out = 1'b0;
    case (state_q)
      S_HEADER: begin
        dstData_out  = {cur_q, lenm1_q};
        dstWrite_out = !dstFull_in && !reset_in;
      end
      S_BURST: begin
        dstData_out  = cur_data_w;
        dstWrite_out = xfer_w;
      end
      default: begin
        dstData_out  = 8'd0;
        dstWrite_out = 1'b0;
      end
    endcase
  end

  always_comb begin
    srcRead_out = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      srcRead_out[i] = xfer_w && (cur_q == 3'(i));
    end
  end

  assign busy_out   = (state_q != S_IDLE);
  assign curSrc_out = cur_q;
  assign remain_out = remain_q;

endmodule

`default_nettype wire

// File: tb/tb_chan_fifo_arbiter.sv
// +--------------------------------------------------------------------------+
// | tb_chan_fifo_arbiter                                                     |
// | Directed scoreboard bench for the round-robin framed-burst arbiter.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_chan_fifo_arbiter;

  localparam int NS = 4;

  logic          clk_in = 1'b0;
  logic          reset_in = 1'b1;
  logic          enable_in = 1'b0;
  logic [NS-1:0] srcMask_in = '0;
  logic [NS*8-1:0] srcData_in = '0;
  logic [NS-1:0] srcEmpty_in = '1;
  logic [NS*8-1:0] srcCount_in = '0;
  logic [NS-1:0] srcRead_out;
  logic [7:0]    dstData_out;
  logic          dstWrite_out;
  logic          dstFull_in = 1'b0;
  logic          busy_out;
  logic [2:0]    curSrc_out;
  logic [5:0]    remain_out;

  chan_fifo_arbiter #(.NUM_SRC(NS), .MAX_BURST(16)) dut (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .enable_in    (enable_in),
    .srcMask_in   (srcMask_in),
    .srcData_in   (srcData_in),
    .srcEmpty_in  (srcEmpty_in),
    .srcCount_in  (srcCount_in),
    .srcRead_out  (srcRead_out),
    .dstData_out  (dstData_out),
    .dstWrite_out (dstWrite_out),
    .dstFull_in   (dstFull_in),
    .busy_out     (busy_out),
    .curSrc_out   (curSrc_out),
    .remain_out   (remain_out)
  );

  always #5 clk_in = ~clk_in;

  logic [7:0] srcq [NS][$];
  logic [7:0] sb [$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int wr_count, rd_count, busy_count, first_wr, last_wr;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clear_stats();
    wr_count = 0; rd_count = 0; busy_count = 0; first_wr = -1; last_wr = -1;
  endtask

  // One clock: present source FIFO state, check outputs before the edge, apply pops.
  task automatic step();
    logic [7:0] exp;
    for (int i = 0; i < NS; i++) begin
      srcEmpty_in[i]        = (srcq[i].size() == 0);
      srcData_in[8*i +: 8]  = (srcq[i].size() != 0) ? srcq[i][0] : 8'h00;
      srcCount_in[8*i +: 8] = (srcq[i].size() > 255) ? 8'hFF : 8'(srcq[i].size());
    end
    #1;
    if (!reset_in) begin
      if (busy_out) busy_count++;
      if (dstFull_in) check("no_strobe_when_full", {27'd0, dstWrite_out, srcRead_out}, 32'd0);
      if (dstWrite_out === 1'b1) begin
        wr_count++;
        if (first_wr < 0) first_wr = cyc;
        last_wr = cyc;
        checks++;
        assert (sb.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write: got %02h expected no write", dstData_out);
        end
        if (sb.size() != 0) begin
          exp = sb.pop_front();
          check("dst_data", {24'd0, dstData_out}, {24'd0, exp});
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (srcRead_out[i] === 1'b1) begin
          rd_count++;
          checks++;
          assert (srcq[i].size() != 0) else begin
            errors++;
            $error("FAIL pop_empty: got pop on source %0d expected none", i);
          end
          if (srcq[i].size() != 0) void'(srcq[i].pop_front());
        end
      end
    end
    cyc++;
    @(negedge clk_in);
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    enable_in = 1'b0;
    srcMask_in = '0;
    dstFull_in = 1'b0;
    for (int i = 0; i < NS; i++) srcq[i].delete();
    sb.delete();
    step();
    step();
    reset_in = 1'b0;
    clear_stats();
  endtask

  task automatic drain(int budget);
    int n = 0;
    while ((sb.size() != 0 || busy_out) && n < budget) begin
      step();
      n++;
    end
    check("drain_scoreboard", sb.size(), 0);
    check("drain_idle", {31'd0, busy_out}, 0);
  endtask

  task automatic run_until_remain(int target, int budget);
    int n = 0;
    while (remain_out !== 6'(target) && n < budget) begin
      step();
      n++;
    end
    check("reach_remain", {26'd0, remain_out}, target);
  endtask

  task automatic fill(int s, int n);
    for (int j = 0; j < n; j++) srcq[s].push_back(8'(s * 64 + j));
  endtask

  initial begin
    int rem [NS];
    int len;
    @(negedge clk_in);

    // Single short burst from source 0
    do_reset();
    check("rst_busy", {31'd0, busy_out}, 0);
    check("rst_write", {31'd0, dstWrite_out}, 0);
    check("rst_read", {28'd0, srcRead_out}, 0);
    check("rst_cur", {29'd0, curSrc_out}, 0);
    check("rst_remain", {26'd0, remain_out}, 0);
    check("rst_data", {24'd0, dstData_out}, 0);
    srcMask_in = 4'b1111;
    enable_in = 1'b1;
    srcq[0].push_back(8'hA0); srcq[0].push_back(8'hA1); srcq[0].push_back(8'hA2);
    sb.push_back(8'h02); sb.push_back(8'hA0); sb.push_back(8'hA1); sb.push_back(8'hA2);
    drain(50);
    check("t1_writes", wr_count, 4);
    check("t1_pops", rd_count, 3);
    check("t1_busy_cycles", busy_count, 4);
    check("t1_consecutive", last_wr - first_wr, 3);

    // Four saturated sources, three rounds of 16/16/8
    do_reset();
    srcMask_in = 4'b1111;
    enable_in = 1'b1;
    for (int s = 0; s < NS; s++) begin
      fill(s, 40);
      rem[s] = 40;
    end
    for (int r = 0; r < 3; r++) begin
      for (int s = 0; s < NS; s++) begin
        len = (rem[s] > 16) ? 16 : rem[s];
        sb.push_back(8'(s * 32 + len - 1));
        for (int j = 0; j < len; j++) sb.push_back(8'(s * 64 + (40 - rem[s]) + j));
        rem[s] -= len;
      end
    end
    drain(1000);
    check("t2_writes", wr_count, 12 + 160);

    // Back-pressure in HEADER (5 cycles) and mid-BURST (3 cycles)
    do_reset();
    srcMask_in = 4'b1111;
    enable_in = 1'b1;
    fill(1, 5);
    sb.push_back(8'h24);
    for (int j = 0; j < 5; j++) sb.push_back(8'(64 + j));
    for (int k = 0; k < 60 && (sb.size() != 0 || busy_out); k++) begin
      dstFull_in = ((k >= 1 && k <= 5) || (k >= 9 && k <= 11));
      step();
    end
    dstFull_in = 1'b0;
    check("t3_drained", sb.size(), 0);
    check("t3_writes", wr_count, 6);
    check("t3_header_cycle", first_wr, cyc - 1 - (wr_count - 1) - 3);

    // enable dropped mid-burst: burst completes, then no new grant
    do_reset();
    srcMask_in = 4'b1111;
    enable_in = 1'b1;
    fill(3, 20);
    sb.push_back(8'h6F);
    for (int j = 0; j < 16; j++) sb.push_back(8'(192 + j));
    run_until_remain(10, 40);
    enable_in = 1'b0;
    drain(100);
    check("t4_left_in_src", srcq[3].size(), 4);
    busy_count = 0;
    repeat (10) step();
    check("t4_no_grant", busy_count, 0);
    enable_in = 1'b1;
    sb.push_back(8'h63);
    for (int j = 16; j < 20; j++) sb.push_back(8'(192 + j));
    drain(100);

    // Only source 2 enabled
    do_reset();
    srcMask_in = 4'b0100;
    enable_in = 1'b1;
    for (int s = 0; s < NS; s++) fill(s, 20);
    sb.push_back(8'h4F);
    for (int j = 0; j < 16; j++) sb.push_back(8'(128 + j));
    sb.push_back(8'h43);
    for (int j = 16; j < 20; j++) sb.push_back(8'(128 + j));
    drain(200);
    busy_count = 0;
    repeat (10) step();
    check("t5_no_grant", busy_count, 0);
    check("t5_src0_untouched", srcq[0].size(), 20);
    check("t5_src3_untouched", srcq[3].size(), 20);

    // Reset mid-burst with remain = 5
    do_reset();
    srcMask_in = 4'b1111;
    enable_in = 1'b1;
    fill(1, 10);
    sb.push_back(8'h29);
    for (int j = 0; j < 10; j++) sb.push_back(8'(64 + j));
    run_until_remain(5, 40);
    reset_in = 1'b1;
    step();
    reset_in = 1'b0;
    sb.delete();
    check("t6_busy", {31'd0, busy_out}, 0);
    check("t6_write", {31'd0, dstWrite_out}, 0);
    check("t6_read", {28'd0, srcRead_out}, 0);
    check("t6_cur", {29'd0, curSrc_out}, 0);
    check("t6_src1_left", srcq[1].size(), 5);
    srcq[0].push_back(8'hB0); srcq[0].push_back(8'hB1); srcq[0].push_back(8'hB2);
    sb.push_back(8'h02); sb.push_back(8'hB0); sb.push_back(8'hB1); sb.push_back(8'hB2);
    sb.push_back(8'h24);
    for (int j = 5; j < 10; j++) sb.push_back(8'(64 + j));
    drain(100);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire

// File: doc/chan_fifo_arbiter.md
Name: chan_fifo_arbiter

Overview:
- Round-robin scheduler that shares one host-read FIFO producer port among NUM_SRC source FIFOs.
- Sits between the per-source FIFO consumer ends and the write side of the FIFO drained by comm_fpga on a read channel.
- Each grant emits one framed burst: a header byte {source ID, length-1}, then up to MAX_BURST payload bytes from the granted source. The host can demultiplex the merged stream using the headers.

Parameters:
- NUM_SRC, 4, number of source FIFOs; legal range 2..8.
- MAX_BURST, 16, maximum payload bytes per burst; legal range 1..32.

Ports:
- clk_in  input  1  system clock (fx2Clk_in domain)
- reset_in  input  1  synchronous, active-high reset
- enable_in  input  1  1 = new grants allowed; a burst already in progress always completes
- srcMask_in  input  NUM_SRC  per-source enable; bit i = 1 makes source i eligible
- srcData_in  input  NUM_SRC*8  source i data at bits [8i+7:8i]; first-word-fall-through, valid while srcEmpty_in[i] = 0
- srcEmpty_in  input  NUM_SRC  source empty flags
- srcCount_in  input  NUM_SRC*8  source data_count values, 8 bits each
- srcRead_out  output  NUM_SRC  pop strobe per source; the pop takes effect at the same rising edge
- dstData_out  output  8  byte to the destination FIFO
- dstWrite_out  output  1  destination write enable
- dstFull_in  input  1  destination full flag
- busy_out  output  1  1 while in HEADER or BURST
- curSrc_out  output  3  index of the last/current granted source
- remain_out  output  6  payload bytes still to send in the current burst

Behaviour:
- Reset (synchronous, with priority over all other activity):
  - state = IDLE, ptr = NUM_SRC-1 (so source 0 wins first), remain = 0, curSrc = 0.
  - All outputs 0.
  - Reset mid-burst abandons the burst with no further writes or pops; the destination may be left holding a partial frame.
- Outputs are combinational from registered state plus dstFull_in and srcEmpty_in. There are no output registers.
  - dstWrite_out and srcRead_out are never 1 while dstFull_in = 1.
- IDLE:
  - Source i is eligible when srcMask_in[i] = 1 and srcEmpty_in[i] = 0.
  - If enable_in = 1 and any source is eligible, grant the first eligible index scanning ptr+1, ptr+2, ... with modulo NUM_SRC wrap.
  - On grant, register cur = index and len = min(srcCount_in[cur], MAX_BURST); use len = 1 if the count reads 0 while not empty. Then remain = len and go to HEADER.
  - No outputs are asserted in IDLE, so arbitration costs 1 cycle.
- HEADER:
  - dstData_out = {cur[2:0], (len-1)[4:0]}, with len-1 held in a register.
  - dstWrite_out = !dstFull_in. On a write edge, go to BURST; otherwise hold.
- BURST:
  - dstData_out = srcData_in[cur].
  - xfer = !dstFull_in && !srcEmpty_in[cur]; dstWrite_out = srcRead_out[cur] = xfer. All other srcRead_out bits are 0.
  - On each xfer edge, remain decrements.
  - On the xfer edge where remain = 1: ptr <= cur, go to IDLE.
  - If the source is empty or the destination is full mid-burst, stall with no timeout. The arbiter is the sole reader of each source, so the latched count guarantees the data.
- Changes to enable_in or srcMask_in during HEADER/BURST are ignored until the next IDLE.
- Throughput: a burst of len bytes occupies len+2 cycles when there is no back-pressure.
- Fairness: a source is granted at most one burst before every other eligible source has had a turn.
- curSrc_out = cur; remain_out = remain; busy_out = (state != IDLE).

Test Plan:
- Reset, then mask=4'b1111, enable=1, source 0 holds 3 bytes A0,A1,A2, others empty, dstFull=0:
  - Expect header 0x02 then A0,A1,A2 on consecutive cycles.
  - Expect srcRead_out[0] pulsed 3 times, busy 4 cycles, then back in IDLE.
- Sources 0..3 each hold 40 bytes, MAX_BURST=16:
  - Expect grant order 0,1,2,3,0,... with headers 0x0F,0x2F,0x4F,0x6F.
  - The third burst for each source carries 8 bytes (header low bits 0x07).
- dstFull held high for 5 cycles in HEADER, then for 3 cycles mid-BURST:
  - dstWrite_out and srcRead_out stay 0 throughout the stalls.
  - The header is written exactly once and the byte order is preserved.
- enable_in dropped during BURST with remain=10:
  - All 10 remaining bytes are sent.
  - No new grant follows until enable_in=1.
- mask=4'b0100, all sources non-empty:
  - Only source 2 is ever granted; every header has bits [7:5]=3'b010.
- reset_in asserted with remain=5:
  - On the next cycle busy_out=0, dstWrite_out=0, srcRead_out=0, and curSrc_out=0.
  - After release, the first grant goes to source 0.
